// File: rtl/video_timing.sv
// Parametrised raster timing generator: pixel-enable divider, H/V counters,
// sync/display-enable decode, character-cell coordinates, line/frame strobes and blink.
module video_timing #(
  parameter int PIX_DIV      = 2,
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int HW           = 10,
  parameter int VW           = 10,
  parameter int CHR_W_LOG2   = 3,
  parameter int CHR_H_LOG2   = 4,
  parameter int BLINK_PERIOD = 60,
  parameter int BLINK_ON     = 30
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  output logic                     pix_en,
  output logic [HW-1:0]            hcnt,
  output logic [VW-1:0]            vcnt,
  output logic [HW-CHR_W_LOG2-1:0] txtcol,
  output logic [VW-CHR_H_LOG2-1:0] txtrow,
  output logic [CHR_W_LOG2-1:0]    chrcol,
  output logic [CHR_H_LOG2-1:0]    chrrow,
  output logic                     de,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     line_start,
  output logic                     frame_start,
  output logic                     blink
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam int BW      = $clog2(BLINK_PERIOD);

  localparam logic [DW-1:0] D_LAST   = DW'(PIX_DIV - 1);
  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [BW-1:0] B_LAST   = BW'(BLINK_PERIOD - 1);
  localparam logic [BW:0]   B_ON     = (BW+1)'(BLINK_ON);
  localparam logic [HW:0]   H_ACT_E  = (HW+1)'(H_ACTIVE);
  localparam logic [HW:0]   H_SYNC_B = (HW+1)'(H_ACTIVE + H_FP);
  localparam logic [HW:0]   H_SYNC_E = (HW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [VW:0]   V_ACT_E  = (VW+1)'(V_ACTIVE);
  localparam logic [VW:0]   V_SYNC_B = (VW+1)'(V_ACTIVE + V_FP);
  localparam logic [VW:0]   V_SYNC_E = (VW+1)'(V_ACTIVE + V_FP + V_SYNC);

  // Reject raster totals that do not fit the counters, and malformed divider/blink settings.
  if ((H_TOTAL > (1 << HW)) || (V_TOTAL > (1 << VW)) || (PIX_DIV < 1) ||
      (BLINK_ON < 1) || (BLINK_ON >= BLINK_PERIOD)) begin : g_param_err
    $error("video_timing: illegal parameter set");
  end

  logic [DW-1:0] dcnt_r, dcnt_nxt_s;
  logic [HW-1:0] hcnt_r, hcnt_nxt_s;
  logic [VW-1:0] vcnt_r, vcnt_nxt_s;
  logic [BW-1:0] bcnt_r, bcnt_nxt_s;
  logic          pix_en_s, h_wrap_s, v_wrap_s;
  logic          de_r, hsync_r, vsync_r, blink_r;
  logic          de_nxt_s, hsync_nxt_s, vsync_nxt_s;

  // Next-state for divider, raster and frame counters, plus decode of the next raster position.
  always_comb begin
    pix_en_s   = run && (dcnt_r == D_LAST);
    h_wrap_s   = (hcnt_r == H_LAST);
    v_wrap_s   = (vcnt_r == V_LAST);
    dcnt_nxt_s = dcnt_r;
    hcnt_nxt_s = hcnt_r;
    vcnt_nxt_s = vcnt_r;
    bcnt_nxt_s = bcnt_r;
    if (!run) begin
      dcnt_nxt_s = '0;
      hcnt_nxt_s = '0;
      vcnt_nxt_s = '0;
    end else if (pix_en_s) begin
      dcnt_nxt_s = '0;
      if (h_wrap_s) begin
        hcnt_nxt_s = '0;
        if (v_wrap_s) begin
          vcnt_nxt_s = '0;
          bcnt_nxt_s = (bcnt_r == B_LAST) ? '0 : bcnt_r + BW'(1);
        end else begin
          vcnt_nxt_s = vcnt_r + VW'(1);
        end
      end else begin
        hcnt_nxt_s = hcnt_r + HW'(1);
      end
    end else begin
      dcnt_nxt_s = dcnt_r + DW'(1);
    end
    // Decoding the next position lets the registered outputs line up with hcnt/vcnt.
    de_nxt_s    = ({1'b0, hcnt_nxt_s} < H_ACT_E) && ({1'b0, vcnt_nxt_s} < V_ACT_E);
    hsync_nxt_s = (({1'b0, hcnt_nxt_s} >= H_SYNC_B) && ({1'b0, hcnt_nxt_s} < H_SYNC_E)) ?
                  HSYNC_POL : ~HSYNC_POL;
    vsync_nxt_s = (({1'b0, vcnt_nxt_s} >= V_SYNC_B) && ({1'b0, vcnt_nxt_s} < V_SYNC_E)) ?
                  VSYNC_POL : ~VSYNC_POL;
  end

  // Counter and decoded-output registers; reset places the raster at the origin.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt_r  <= '0;
      hcnt_r  <= '0;
      vcnt_r  <= '0;
      bcnt_r  <= '0;
      de_r    <= 1'b1;
      hsync_r <= ~HSYNC_POL;
      vsync_r <= ~VSYNC_POL;
      blink_r <= 1'b1;
    end else begin
      dcnt_r  <= dcnt_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
      vcnt_r  <= vcnt_nxt_s;
      bcnt_r  <= bcnt_nxt_s;
      de_r    <= de_nxt_s;
      hsync_r <= hsync_nxt_s;
      vsync_r <= vsync_nxt_s;
      blink_r <= ({1'b0, bcnt_r} < B_ON);
    end
  end

  assign pix_en      = pix_en_s;
  assign hcnt        = hcnt_r;
  assign vcnt        = vcnt_r;
  assign txtcol      = hcnt_r[HW-1:CHR_W_LOG2];
  assign txtrow      = vcnt_r[VW-1:CHR_H_LOG2];
  assign chrcol      = hcnt_r[CHR_W_LOG2-1:0];
  assign chrrow      = vcnt_r[CHR_H_LOG2-1:0];
  assign de          = de_r;
  assign hsync       = hsync_r;
  assign vsync       = vsync_r;
  assign line_start  = pix_en_s && (hcnt_r == '0);
  assign frame_start = pix_en_s && (hcnt_r == '0) && (vcnt_r == '0);
  assign blink       = blink_r;

endmodule
